dct_row_quant_pipe: RTL

//  Pipelined 8-point 1-D row DCT with per-row, per-coefficient quantisation
//  and signed saturation. Successor to the combinational second-pass DCT.

---
 rtl/dct_row_quant_pipe.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dct_row_quant_pipe.sv
// dct_row_quant_pipe: 8-point 1-D row DCT (first NUM_OUT coefficients) with
// per-row/per-coefficient quantisation and signed saturation. Four register
// stages (capture, butterfly, scale*quant, saturate) behind valid/ready.
// A single global stall freezes every stage while the output is blocked.
module dct_row_quant_pipe #(
  parameter int IN_W    = 9,
  parameter int OUT_W   = 10,
  parameter int Q_W     = 7,
  parameter int SHIFT   = 5,
  parameter int NUM_OUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [8*IN_W-1:0]    in_data,
  input  logic                 qt_we,
  input  logic [4:0]           qt_addr,
  input  logic [Q_W-1:0]       qt_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   out_data,
  output logic [2:0]           out_row,
  output logic                 out_eob
);
  localparam int AW = IN_W + 1;
  localparam int BW = IN_W + 2;
  localparam int CW = IN_W + 3;
  localparam int PW = 32;
  localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (OUT_W - 1)));

  logic                  stall, accept;
  logic [Q_W-1:0]        qt_q [32];
  logic [2:0]            rowcnt_q, rowcnt_d, row_sel;
  logic [Q_W-1:0]        q_sel [4];

  logic                  v0_q;
  logic [2:0]            row0_q;
  logic signed [IN_W-1:0] x0_q [8];
  logic [Q_W-1:0]        q0_q [4];

  logic signed [AW-1:0]  a [8];
  logic signed [BW-1:0]  b1, b2;
  logic signed [CW-1:0]  c1_d, c1_q;
  logic signed [BW-1:0]  b3_d, b4_d, b5_d, b6_d, b3_q, b4_q, b5_q, b6_q;
  logic signed [AW-1:0]  a5_q, a7_q;
  logic                  v1_q;
  logic [2:0]            row1_q;
  logic [Q_W-1:0]        q1_q [4];

  logic signed [PW-1:0]  p_d [4];
  logic signed [PW-1:0]  p_q [4];
  logic                  v2_q;
  logic [2:0]            row2_q;

  logic signed [PW-1:0]  sat_t;
  logic [8*OUT_W-1:0]    y_d;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Row index selection and quant factor lookup for the row being offered.
  always_comb begin
    row_sel  = in_sof ? 3'd0 : rowcnt_q;
    rowcnt_d = accept ? 3'(row_sel + 3'd1) : rowcnt_q;
    for (int k = 0; k < 4; k++) q_sel[k] = qt_q[{2'(k), row_sel}];
  end

  // Row counter; wraps 7 -> 0 naturally in 3 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rowcnt_q <= '0;
    else        rowcnt_q <= rowcnt_d;
  end

  // Quant table: writable any cycle; a row accepted on the write edge reads the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) qt_q[i] <= Q_W'(1);
    end else if (qt_we) begin
      qt_q[qt_addr] <= qt_wdata;
    end
  end

  // Stage 0: capture the accepted row with its index and quant factors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      row0_q <= '0;
      for (int i = 0; i < 8; i++) x0_q[i] <= '0;
      for (int k = 0; k < 4; k++) q0_q[k] <= '0;
    end else if (!stall) begin
      v0_q <= accept;
      if (accept) begin
        row0_q <= row_sel;
        for (int i = 0; i < 8; i++) x0_q[i] <= in_data[(7-i)*IN_W +: IN_W];
        for (int k = 0; k < 4; k++) q0_q[k] <= q_sel[k];
      end
    end
  end

  // Butterfly network at full precision.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]   = AW'(x0_q[i]) + AW'(x0_q[7-i]);
      a[i+4] = AW'(x0_q[i]) - AW'(x0_q[7-i]);
    end
    b1   = BW'(a[0]) + BW'(a[3]);
    b2   = BW'(a[1]) + BW'(a[2]);
    b3_d = BW'(a[0]) - BW'(a[3]);
    b4_d = BW'(a[1]) - BW'(a[2]);
    b5_d = BW'(a[5]) + BW'(a[6]);
    b6_d = BW'(a[4]) - BW'(a[7]);
    c1_d = CW'(b1) + CW'(b2);
  end

  // Stage 1: register the butterfly terms the multipliers need.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; row1_q <= '0; c1_q <= '0;
      b3_q <= '0; b4_q <= '0; b5_q <= '0; b6_q <= '0; a5_q <= '0; a7_q <= '0;
      for (int k = 0; k < 4; k++) q1_q[k] <= '0;
    end else if (!stall) begin
      v1_q <= v0_q; row1_q <= row0_q; c1_q <= c1_d;
      b3_q <= b3_d; b4_q <= b4_d; b5_q <= b5_d; b6_q <= b6_d;
      a5_q <= a[4]; a7_q <= a[6];
      for (int k = 0; k < 4; k++) q1_q[k] <= q0_q[k];
    end
  end

  // Fixed-point DCT scale times the (unsigned) quant factor; 32 bits cannot overflow.
  always_comb begin
    p_d[0] = PW'(c1_q) * 32'sd45 * PW'($signed({1'b0, q1_q[0]}));
    p_d[1] = (PW'(b5_q) * 32'sd32 + PW'(a5_q) * 32'sd64) * PW'($signed({1'b0, q1_q[1]}));
    p_d[2] = (PW'(b3_q) * 32'sd56 + PW'(b4_q) * 32'sd24) * PW'($signed({1'b0, q1_q[2]}));
    p_d[3] = (PW'(b6_q) * 32'sd32 - PW'(a7_q) * 32'sd64) * PW'($signed({1'b0, q1_q[3]}));
  end

  // Stage 2: register the products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0; row2_q <= '0;
      for (int k = 0; k < 4; k++) p_q[k] <= '0;
    end else if (!stall) begin
      v2_q <= v1_q; row2_q <= row1_q;
      for (int k = 0; k < 4; k++) p_q[k] <= p_d[k];
    end
  end

  // Floor shift and clamp each computed coefficient; unused slots stay zero.
  always_comb begin
    y_d   = '0;
    sat_t = '0;
    for (int k = 0; k < 4; k++) begin
      sat_t = p_q[k] >>> SHIFT;
      if (k < NUM_OUT) begin
        if (sat_t > SAT_MAX)      y_d[(7-k)*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        else if (sat_t < SAT_MIN) y_d[(7-k)*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        else                      y_d[(7-k)*OUT_W +: OUT_W] = sat_t[OUT_W-1:0];
      end
    end
  end

  // Output stage: holds while the downstream is not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; out_data <= '0; out_row <= '0; out_eob <= 1'b0;
    end else if (!stall) begin
      out_valid <= v2_q;
      out_eob   <= v2_q && (row2_q == 3'd7);
      if (v2_q) begin
        out_data <= y_d;
        out_row  <= row2_q;
      end
    end
  end

endmodule
